// File: rtl/hdmi_pkg.sv
// Shared types and helpers for the Avalon-ST to HDMI raster timing block.
// Holds the lock FSM states, the counter width and the raster timing description.
package hdmi_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        UNLOCKED,
        WAIT_FRAME,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
        logic [CNT_W-1:0] bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_t;

    function automatic logic [CNT_W-1:0] axis_total(axis_timing_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic logic [CNT_W-1:0] sync_start(axis_timing_t a);
        return a.active + a.fp;
    endfunction

endpackage

// File: rtl/hdmi_raster_cnt.sv
// Free-running horizontal/vertical raster counters with sync and active decode.
// All decoded outputs are combinational from the current counter state.
module hdmi_raster_cnt
    import hdmi_pkg::*;
#(
    parameter timing_t TIMING = '{
        h: '{active: CNT_W'(640), fp: CNT_W'(16), sync: CNT_W'(96), bp: CNT_W'(48)},
        v: '{active: CNT_W'(480), fp: CNT_W'(10), sync: CNT_W'(2),  bp: CNT_W'(33)}
    },
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_first,
    output logic             frame_last
);

    localparam logic [CNT_W-1:0] H_LAST = axis_total(TIMING.h) - CNT_W'(1);
    localparam logic [CNT_W-1:0] V_LAST = axis_total(TIMING.v) - CNT_W'(1);
    localparam logic [CNT_W-1:0] HS_BEG = sync_start(TIMING.h);
    localparam logic [CNT_W-1:0] HS_END = HS_BEG + TIMING.h.sync;
    localparam logic [CNT_W-1:0] VS_BEG = sync_start(TIMING.v);
    localparam logic [CNT_W-1:0] VS_END = VS_BEG + TIMING.v.sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign active      = (hcnt < TIMING.h.active) && (vcnt < TIMING.v.active);
    assign hsync       = (hcnt >= HS_BEG && hcnt < HS_END) ? HS_POL : ~HS_POL;
    assign vsync       = (vcnt >= VS_BEG && vcnt < VS_END) ? VS_POL : ~VS_POL;
    assign frame_first = (hcnt == '0) && (vcnt == '0);
    // Last active pixel of the frame, where the packet's EOP must land
    assign frame_last  = (hcnt == TIMING.h.active - CNT_W'(1)) &&
                         (vcnt == TIMING.v.active - CNT_W'(1));

endmodule

// File: rtl/hdmi_st_timing.sv
// Aligns an Avalon-ST pixel stream (one packet per frame) to a generated video raster.
// Outputs are registered one cycle after the raster counter state they describe.
module hdmi_st_timing
    import hdmi_pkg::*;
#(
    parameter int              H_ACTIVE = 640,
    parameter int              H_FP     = 16,
    parameter int              H_SYNC   = 96,
    parameter int              H_BP     = 48,
    parameter int              V_ACTIVE = 480,
    parameter int              V_FP     = 10,
    parameter int              V_SYNC   = 2,
    parameter int              V_BP     = 33,
    parameter bit              HS_POL   = 1'b0,
    parameter bit              VS_POL   = 1'b0,
    parameter int              DATA_W   = 24,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] st_in_data,
    input  logic              st_in_valid,
    input  logic              st_in_startofpacket,
    input  logic              st_in_endofpacket,
    output logic              st_in_ready,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_de,
    output logic              vid_hsync,
    output logic              vid_vsync,
    output logic [CNT_W-1:0]  hdmi_x,
    output logic [CNT_W-1:0]  hdmi_y,
    output logic              locked,
    output logic              err_underflow,
    output logic              err_sync
);

    localparam timing_t TIMING = '{
        h: '{active: CNT_W'(H_ACTIVE), fp: CNT_W'(H_FP), sync: CNT_W'(H_SYNC), bp: CNT_W'(H_BP)},
        v: '{active: CNT_W'(V_ACTIVE), fp: CNT_W'(V_FP), sync: CNT_W'(V_SYNC), bp: CNT_W'(V_BP)}
    };
    localparam bit ONE_PIX = (H_ACTIVE * V_ACTIVE == 1);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              active;
    logic              hsync;
    logic              vsync;
    logic              frame_first;
    logic              frame_last;
    state_t            state;
    logic [DATA_W-1:0] hold;
    logic              run;
    logic              accept;
    logic              sync_bad;

    hdmi_raster_cnt #(
        .TIMING (TIMING),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) u_raster (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    // run keeps ready low until the first clock edge after reset release
    always_comb begin
        st_in_ready = 1'b0;
        if (run) begin
            case (state)
                UNLOCKED:   st_in_ready = 1'b1;
                WAIT_FRAME: st_in_ready = 1'b0;
                LOCKED:     st_in_ready = active;
                default:    st_in_ready = 1'b0;
            endcase
        end
    end

    assign accept   = st_in_ready && st_in_valid;
    assign sync_bad = (st_in_startofpacket != frame_first) || (st_in_endofpacket != frame_last);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= UNLOCKED;
            hold          <= '0;
            run           <= 1'b0;
            vid_data      <= '0;
            vid_de        <= 1'b0;
            vid_hsync     <= ~HS_POL;
            vid_vsync     <= ~VS_POL;
            hdmi_x        <= '0;
            hdmi_y        <= '0;
            locked        <= 1'b0;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            run           <= 1'b1;
            vid_de        <= active;
            vid_data      <= active ? FILL : '0;
            vid_hsync     <= hsync;
            vid_vsync     <= vsync;
            hdmi_x        <= hcnt;
            hdmi_y        <= vcnt;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (accept && st_in_startofpacket) begin
                        if (st_in_endofpacket && !ONE_PIX) begin
                            err_sync <= 1'b1;
                        end else begin
                            hold  <= st_in_data;
                            state <= WAIT_FRAME;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_first) begin
                        vid_data <= hold;
                        state    <= LOCKED;
                        locked   <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Ready equals active here, so every active pixel is a handshake slot
                    if (active) begin
                        if (!st_in_valid) begin
                            err_underflow <= 1'b1;
                        end else if (sync_bad) begin
                            err_sync <= 1'b1;
                            state    <= UNLOCKED;
                            locked   <= 1'b0;
                        end else begin
                            vid_data <= st_in_data;
                        end
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_st_timing.sv
// Directed bench for hdmi_st_timing on a 7x6 raster (4x3 active, 12-pixel frames).
// Cycle k counts pixel clocks since reset release; the output seen after edge k is raster pixel k-1.
module tb_hdmi_st_timing;

    localparam int                DATA_W = 24;
    localparam logic [DATA_W-1:0] FILL   = 24'hF1F1F1;

    logic              clk_clk       = 1'b0;
    logic              reset_reset_n = 1'b1;
    logic [DATA_W-1:0] st_in_data;
    logic              st_in_valid;
    logic              st_in_startofpacket;
    logic              st_in_endofpacket;
    logic              st_in_ready;
    logic [DATA_W-1:0] vid_data;
    logic              vid_de;
    logic              vid_hsync;
    logic              vid_vsync;
    logic [10:0]       hdmi_x;
    logic [10:0]       hdmi_y;
    logic              locked;
    logic              err_underflow;
    logic              err_sync;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int pkt   = 0;
    int beat  = 0;
    int gap_p = -1;
    int sop_p = -1;

    always #5 clk_clk = ~clk_clk;

    hdmi_st_timing #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0),
        .DATA_W   (DATA_W), .FILL (FILL)
    ) dut (
        .clk_clk             (clk_clk),
        .reset_reset_n       (reset_reset_n),
        .st_in_data          (st_in_data),
        .st_in_valid         (st_in_valid),
        .st_in_startofpacket (st_in_startofpacket),
        .st_in_endofpacket   (st_in_endofpacket),
        .st_in_ready         (st_in_ready),
        .vid_data            (vid_data),
        .vid_de              (vid_de),
        .vid_hsync           (vid_hsync),
        .vid_vsync           (vid_vsync),
        .hdmi_x              (hdmi_x),
        .hdmi_y              (hdmi_y),
        .locked              (locked),
        .err_underflow       (err_underflow),
        .err_sync            (err_sync)
    );

    function automatic logic [DATA_W-1:0] beat_word(int p, int b);
        return {8'(p + 1), 8'h5A, 8'(b)};
    endfunction

    function automatic int pkt_len(int p);
        return (p == 5) ? 11 : 12;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixel(input string tag, input int x, input int y,
                               input logic [DATA_W-1:0] d, input logic de, input logic lk);
        check_output({tag, ".x"},      32'(hdmi_x), 32'(x));
        check_output({tag, ".y"},      32'(hdmi_y), 32'(y));
        check_output({tag, ".data"},   32'(vid_data), 32'(d));
        check_output({tag, ".de"},     32'(vid_de), 32'(de));
        check_output({tag, ".locked"}, 32'(locked), 32'(lk));
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, ".data"},  32'(vid_data), 32'h0);
        check_output({tag, ".de"},    32'(vid_de), 32'h0);
        check_output({tag, ".hsync"}, 32'(vid_hsync), 32'h1);
        check_output({tag, ".vsync"}, 32'(vid_vsync), 32'h1);
        check_output({tag, ".x"},     32'(hdmi_x), 32'h0);
        check_output({tag, ".y"},     32'(hdmi_y), 32'h0);
        check_output({tag, ".locked"},32'(locked), 32'h0);
        check_output({tag, ".unf"},   32'(err_underflow), 32'h0);
        check_output({tag, ".serr"},  32'(err_sync), 32'h0);
        check_output({tag, ".ready"}, 32'(st_in_ready), 32'h0);
    endtask

    // Presents the current beat for the pixel consumed at the next rising edge (pixel index k)
    task automatic drive_source();
        st_in_data          = beat_word(pkt, beat);
        st_in_valid         = (k != gap_p);
        st_in_startofpacket = (beat == 0) || (k == sop_p);
        st_in_endofpacket   = (beat == pkt_len(pkt) - 1);
    endtask

    task automatic apply_stimulus();
        logic hs;
        hs = st_in_ready && st_in_valid;
        @(negedge clk_clk);
        k++;
        if (hs) begin
            if (beat == pkt_len(pkt) - 1) begin
                pkt++;
                beat = 0;
            end else begin
                beat++;
            end
        end
        drive_source();
    endtask

    task automatic run_to(input int target);
        while (k < target) apply_stimulus();
    endtask

    initial begin
        st_in_data          = '0;
        st_in_valid         = 1'b0;
        st_in_startofpacket = 1'b0;
        st_in_endofpacket   = 1'b0;
        #1 reset_reset_n = 1'b0;
        #11;
        check_reset_values("rst0");

        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        k = 0; pkt = 0; beat = 0;
        drive_source();
        check_output("ready_pre_edge", 32'(st_in_ready), 32'h0);

        run_to(1);
        check_pixel("f0_p00", 0, 0, FILL, 1'b1, 1'b0);
        check_output("ready_unlocked", 32'(st_in_ready), 32'h1);
        run_to(2);
        check_pixel("f0_p10", 1, 0, FILL, 1'b1, 1'b0);
        check_output("ready_wait", 32'(st_in_ready), 32'h0);
        run_to(5);
        check_pixel("f0_p40", 4, 0, 24'h0, 1'b0, 1'b0);
        check_output("hs_h4", 32'(vid_hsync), 32'h1);
        run_to(6);
        check_output("hs_h5", 32'(vid_hsync), 32'h0);
        check_output("hs_h5.x", 32'(hdmi_x), 32'h5);
        run_to(7);
        check_output("hs_h6", 32'(vid_hsync), 32'h1);
        run_to(22);
        check_pixel("f0_p03", 0, 3, 24'h0, 1'b0, 1'b0);
        check_output("vs_v3", 32'(vid_vsync), 32'h1);
        run_to(29);
        check_output("vs_v4", 32'(vid_vsync), 32'h0);
        check_output("vs_v4.y", 32'(hdmi_y), 32'h4);
        check_output("vs_v4.hs", 32'(vid_hsync), 32'h1);
        run_to(36);
        check_output("vs_v5", 32'(vid_vsync), 32'h1);
        run_to(42);
        check_output("ready_wait_00", 32'(st_in_ready), 32'h0);
        check_output("locked_pre", 32'(locked), 32'h0);

        run_to(43);
        check_pixel("f1_p00", 0, 0, beat_word(0, 0), 1'b1, 1'b1);
        run_to(44);
        check_pixel("f1_p10", 1, 0, beat_word(0, 1), 1'b1, 1'b1);
        run_to(54);
        check_pixel("f1_p41", 4, 1, 24'h0, 1'b0, 1'b1);
        run_to(58);
        check_pixel("f1_p12", 1, 2, beat_word(0, 9), 1'b1, 1'b1);
        run_to(60);
        check_pixel("f1_p32", 3, 2, beat_word(0, 11), 1'b1, 1'b1);
        check_output("f1_serr", 32'(err_sync), 32'h0);
        run_to(85);
        check_pixel("f2_p00", 0, 0, beat_word(1, 0), 1'b1, 1'b1);

        gap_p = 93;
        run_to(94);
        check_pixel("unf_p21", 2, 1, FILL, 1'b1, 1'b1);
        check_output("unf_pulse", 32'(err_underflow), 32'h1);
        run_to(95);
        check_pixel("unf_p31", 3, 1, beat_word(1, 6), 1'b1, 1'b1);
        check_output("unf_clear", 32'(err_underflow), 32'h0);
        run_to(102);
        check_pixel("slip_p32", 3, 2, FILL, 1'b1, 1'b0);
        check_output("slip_serr", 32'(err_sync), 32'h1);
        run_to(103);
        check_output("slip_serr_clear", 32'(err_sync), 32'h0);
        run_to(110);
        check_output("slip_ready_wait", 32'(st_in_ready), 32'h0);
        run_to(127);
        check_pixel("f3_p00", 0, 0, beat_word(2, 0), 1'b1, 1'b1);

        sop_p = 169;
        run_to(169);
        check_output("sop_locked_before", 32'(locked), 32'h1);
        run_to(170);
        check_pixel("sop_p10", 1, 0, FILL, 1'b1, 1'b0);
        check_output("sop_serr", 32'(err_sync), 32'h1);
        run_to(171);
        check_pixel("sop_p20", 2, 0, FILL, 1'b1, 1'b0);
        check_output("sop_serr_clear", 32'(err_sync), 32'h0);
        run_to(186);
        check_pixel("sop_p32", 3, 2, FILL, 1'b1, 1'b0);
        run_to(211);
        check_pixel("f5_p00", 0, 0, beat_word(4, 0), 1'b1, 1'b1);
        run_to(212);
        check_pixel("f5_p10", 1, 0, beat_word(4, 1), 1'b1, 1'b1);

        run_to(253);
        check_pixel("f6_p00", 0, 0, beat_word(5, 0), 1'b1, 1'b1);
        run_to(268);
        check_pixel("f6_p12", 1, 2, beat_word(5, 9), 1'b1, 1'b1);
        run_to(269);
        check_pixel("eop_p22", 2, 2, FILL, 1'b1, 1'b0);
        check_output("eop_serr", 32'(err_sync), 32'h1);
        check_output("eop_unf", 32'(err_underflow), 32'h0);
        run_to(270);
        check_pixel("eop_p32", 3, 2, FILL, 1'b1, 1'b0);
        run_to(295);
        check_pixel("f7_p00", 0, 0, beat_word(6, 0), 1'b1, 1'b1);

        run_to(296);
        check_pixel("f7_p10", 1, 0, beat_word(6, 1), 1'b1, 1'b1);
        #3 reset_reset_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        k = 0; pkt = 10; beat = 0; gap_p = -1; sop_p = -1;
        drive_source();
        run_to(1);
        check_pixel("rr_p00", 0, 0, FILL, 1'b1, 1'b0);
        run_to(2);
        check_pixel("rr_p10", 1, 0, FILL, 1'b1, 1'b0);
        run_to(43);
        check_pixel("rr_f1_p00", 0, 0, beat_word(10, 0), 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
